axi_master_bridge: RTL and testbench
====================================

Name: axi_master_bridge

Overview:
- Initiator-side AXI4 bridge. Converts one CPU/core memory request port into single-beat AXI4 read and write transactions toward the interconnect.
- It is the counterpart of the slave-side responders, including the default (DECERR) slave.
- Exactly one transaction is in flight at a time. The core is stalled until completion.

Parameters:
- ID, default 4'd0: value driven on ARID_M/AWID_M; width `AXI_ID_BITS.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width; STRB_W = DATA_W/8.

Ports:
- clk  input  1  clock; everything is sampled on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  1  core request; held with its fields stable until stall drops.
- we  input  1  1 = write, 0 = read.
- addr  input  ADDR_W  byte address.
- wdata  input  DATA_W  write data.
- wstrb  input  STRB_W  write byte enables.
- rdata  output  DATA_W  read data, registered.
- stall  output  1  core must hold its request.
- err  output  1  one-cycle pulse when the completing response is not OKAY.
- ARID_M/AWID_M  output  `AXI_ID_BITS  read/write IDs.
- ARADDR_M/AWADDR_M  output  ADDR_W  read/write addresses.
- ARLEN_M/AWLEN_M  output  4  burst length, constant 0.
- ARSIZE_M/AWSIZE_M  output  3  burst size, constant 3'b010.
- ARBURST_M/AWBURST_M  output  2  burst type, constant INCR 2'b01.
- ARVALID_M/AWVALID_M/WVALID_M/RREADY_M/BREADY_M  output  1  channel handshakes.
- ARREADY_M/AWREADY_M/WREADY_M/RVALID_M/BVALID_M/RLAST_M  input  1  channel handshakes.
- WDATA_M  output  DATA_W; WSTRB_M  output  STRB_W; WLAST_M  output  1 (driven equal to WVALID_M).
- RDATA_M  input  DATA_W; RID_M/BID_M  input  `AXI_ID_BITS; RRESP_M/BRESP_M  input  2.

Behaviour:
- Reset: state IDLE. All VALID/READY outputs are 0, rdata = 0, err = 0, stall = 0. AW/W done flags are cleared.
- Reset mid-transaction abandons it; the bench must also reset the slave side.
- States:
  - IDLE: on req & !we, latch addr and go to AR. On req & we, latch addr, wdata and wstrb and go to WR. stall = req combinationally, so the core sees the stall in the same cycle it raises req.
  - AR: ARVALID_M = 1 until ARVALID_M & ARREADY_M, then go to R. ARVALID_M is never withdrawn before the handshake.
  - R: RREADY_M = 1. On RVALID_M, latch rdata = RDATA_M, set err = (RRESP_M != OKAY), go to DONE.
  - WR: AWVALID_M and WVALID_M are asserted together, each dropped independently after its own handshake (aw_done, w_done flags). When both are done, go to B. If both handshakes happen in the same cycle, go directly to B.
  - B: BREADY_M = 1. On BVALID_M, set err = (BRESP_M != OKAY) and go to DONE.
  - DONE: stall = 0 for exactly one cycle and err is valid in this cycle. Return to IDLE.
- Minimum latencies, measured from req to stall = 0 with zero-wait slaves:
  - Read: 4 cycles (IDLE→AR→R→DONE).
  - Write: 4 cycles.
- Mismatched RID_M/BID_M or RLAST_M = 0 is treated as a SLVERR response: err pulses.
- Address and data outputs hold their latched values from issue until the handshake; they never change while VALID is high.
- A DECERR response from the default slave yields rdata = RDATA_M as received (0 from that slave) plus an err pulse.

Optional Feature:
- Macro: AXI_MASTER_POSTED_WRITE_EN.
- Defined:
  - WR proceeds to DONE once both AW and W are accepted; stall is released without waiting for B.
  - A b_pending flag keeps BREADY_M = 1 until BVALID_M.
  - A new request arriving while b_pending = 1 stalls in IDLE until B is received.
  - A non-OKAY BRESP sets a sticky err that is cleared only by rst.
- Undefined: behaviour is exactly as in the Behaviour section.

Decomposition:
- Package axi_master_pkg holds:
  - enum state_t {IDLE, AR, R, WR, B, DONE};
  - enum resp_t {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11};
  - constants SIZE_WORD = 3'b010 and BURST_INCR = 2'b01.
- One sub-module is natural: axi_master_wchan, which owns the aw_done/w_done flags and independent AW/W VALID release, and outputs both_done.

Test Plan:
- Read 0x0000_1000 from a slave with ARREADY = 1, RVALID the next cycle, RDATA = 0xDEAD_BEEF, RRESP = OKAY → rdata = 0xDEAD_BEEF, err = 0, stall drops 4 cycles after req.
- Write 0x1234_5678 with wstrb = 4'b0011, where AWREADY arrives 3 cycles before WREADY → AWVALID drops first, WVALID holds until its handshake, WDATA/WSTRB are stable throughout, B OKAY gives err = 0.
- Read to an unmapped address answered by the default slave (DECERR) → err pulses exactly 1 cycle, rdata = 0, state returns to IDLE.
- ARREADY held low for 10 cycles → ARVALID stays 1 and ARADDR is unchanged for all 10 cycles, and stall stays 1.
- rst asserted while in B → the next cycle has state IDLE and all VALID/READY = 0; a fresh read then completes correctly.
- With AXI_MASTER_POSTED_WRITE_EN: write, then a read issued immediately, with BVALID delayed 5 cycles → the write's stall releases before B, ARVALID is not raised until B is received, and SLVERR on B latches sticky err = 1.

Source files
------------

// File: rtl/axi_master_bridge_pkg.sv
// ============================================================================
// Module      : axi_master_pkg
// Description : Shared types and constants for the single-beat AXI4 master
//               bridge (FSM states, response codes, fixed burst attributes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

package axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        WR   = 3'd3,
        B    = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

endpackage

`default_nettype wire

// File: rtl/axi_master_bridge_wchan.sv
// ============================================================================
// Module      : axi_master_wchan
// Description : AW/W issue tracker. Both VALIDs rise together; each drops on
//               its own handshake. both_done marks the cycle the pair is done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_master_wchan (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_awready,
    input  logic i_wready,
    output logic o_awvalid,
    output logic o_wvalid,
    output logic o_both_done
);

    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;
    logic w_w_hs;

    assign o_awvalid   = i_active & ~r_aw_done;
    assign o_wvalid    = i_active & ~r_w_done;
    assign w_aw_hs     = o_awvalid & i_awready;
    assign w_w_hs      = o_wvalid & i_wready;
    // Counts a handshake happening this very cycle, so simultaneous acceptance
    // completes without an extra wait cycle.
    assign o_both_done = i_active & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    always_ff @(posedge clk) begin
        if (rst || o_both_done || !i_active) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_master_bridge.sv
// ============================================================================
// Module      : axi_master_bridge
// Description : Core request port to single-beat AXI4 read/write master, one
//               transaction in flight. Optional AXI_MASTER_POSTED_WRITE_EN
//               releases write stalls before the B response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import axi_master_pkg::*;

module axi_master_bridge #(
    parameter logic [`AXI_ID_BITS-1:0] ID = '0,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [STRB_W-1:0]       wstrb,
    output logic [DATA_W-1:0]       rdata,
    output logic                    stall,
    output logic                    err,
    output logic [`AXI_ID_BITS-1:0] ARID_M,
    output logic [ADDR_W-1:0]       ARADDR_M,
    output logic [3:0]              ARLEN_M,
    output logic [2:0]              ARSIZE_M,
    output logic [1:0]              ARBURST_M,
    output logic                    ARVALID_M,
    input  logic                    ARREADY_M,
    input  logic [`AXI_ID_BITS-1:0] RID_M,
    input  logic [DATA_W-1:0]       RDATA_M,
    input  logic [1:0]              RRESP_M,
    input  logic                    RLAST_M,
    input  logic                    RVALID_M,
    output logic                    RREADY_M,
    output logic [`AXI_ID_BITS-1:0] AWID_M,
    output logic [ADDR_W-1:0]       AWADDR_M,
    output logic [3:0]              AWLEN_M,
    output logic [2:0]              AWSIZE_M,
    output logic [1:0]              AWBURST_M,
    output logic                    AWVALID_M,
    input  logic                    AWREADY_M,
    output logic [DATA_W-1:0]       WDATA_M,
    output logic [STRB_W-1:0]       WSTRB_M,
    output logic                    WLAST_M,
    output logic                    WVALID_M,
    input  logic                    WREADY_M,
    input  logic [`AXI_ID_BITS-1:0] BID_M,
    input  logic [1:0]              BRESP_M,
    input  logic                    BVALID_M,
    output logic                    BREADY_M
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                w_stall;
    logic                w_latch;
    logic                w_both_done;
    logic                w_b_block;
    logic                w_r_bad;
    logic                w_b_bad;

    // Wrong ID or a missing RLAST is reported the same way as SLVERR.
    assign w_r_bad = (RRESP_M != OKAY) || (RID_M != ID) || !RLAST_M;
    assign w_b_bad = (BRESP_M != OKAY) || (BID_M != ID);

`ifdef AXI_MASTER_POSTED_WRITE_EN
    localparam bit c_posted = 1'b1;

    logic r_b_pending;
    logic r_err_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_pending  <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_both_done) begin
                r_b_pending <= 1'b1;
            end else if (r_b_pending && BVALID_M) begin
                r_b_pending <= 1'b0;
                if (w_b_bad) r_err_sticky <= 1'b1;
            end
        end
    end

    assign BREADY_M  = r_b_pending;
    assign w_b_block = r_b_pending;
    assign err       = r_err | r_err_sticky;
`else
    localparam bit c_posted = 1'b0;

    assign BREADY_M  = (r_state == B);
    assign w_b_block = 1'b0;
    assign err       = r_err;
`endif

    axi_master_wchan u_wchan (
        .clk         (clk),
        .rst         (rst),
        .i_active    (r_state == WR),
        .i_awready   (AWREADY_M),
        .i_wready    (WREADY_M),
        .o_awvalid   (AWVALID_M),
        .o_wvalid    (WVALID_M),
        .o_both_done (w_both_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                // Combinational so the core stalls in the cycle it asks.
                w_stall = req;
                if (req && !w_b_block) begin
                    w_latch     = 1'b1;
                    w_state_nxt = we ? WR : AR;
                end
            end
            AR: begin
                w_stall = 1'b1;
                if (ARREADY_M) w_state_nxt = R;
            end
            R: begin
                w_stall = 1'b1;
                if (RVALID_M) w_state_nxt = DONE;
            end
            WR: begin
                w_stall = 1'b1;
                if (w_both_done) w_state_nxt = c_posted ? DONE : B;
            end
            B: begin
                w_stall = 1'b1;
                if (BVALID_M) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_addr <= addr;
                if (we) begin
                    r_wdata <= wdata;
                    r_wstrb <= wstrb;
                end
            end
            // err is a single-cycle pulse aligned with DONE.
            r_err <= 1'b0;
            if (r_state == R && RVALID_M) begin
                r_rdata <= RDATA_M;
                r_err   <= w_r_bad;
            end else if (r_state == B && BVALID_M) begin
                r_err   <= w_b_bad;
            end
        end
    end

    assign rdata     = r_rdata;
    assign stall     = w_stall;

    assign ARID_M    = ID;
    assign ARADDR_M  = r_addr;
    assign ARLEN_M   = LEN_SINGLE;
    assign ARSIZE_M  = SIZE_WORD;
    assign ARBURST_M = BURST_INCR;
    assign ARVALID_M = (r_state == AR);
    assign RREADY_M  = (r_state == R);

    assign AWID_M    = ID;
    assign AWADDR_M  = r_addr;
    assign AWLEN_M   = LEN_SINGLE;
    assign AWSIZE_M  = SIZE_WORD;
    assign AWBURST_M = BURST_INCR;
    assign WDATA_M   = r_wdata;
    assign WSTRB_M   = r_wstrb;
    assign WLAST_M   = WVALID_M;

endmodule

`default_nettype wire

// File: tb/tb_axi_master_bridge.sv
// ============================================================================
// Module      : tb_axi_master_bridge
// Description : Directed bench for axi_master_bridge with a behavioural AXI
//               slave and an expected-result queue popped at each completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module tb_axi_master_bridge;
    import axi_master_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        stall, err;
    logic [`AXI_ID_BITS-1:0] ARID_M, AWID_M, RID_M, BID_M;
    logic [31:0] ARADDR_M, AWADDR_M, RDATA_M, WDATA_M;
    logic [3:0]  ARLEN_M, AWLEN_M, WSTRB_M;
    logic [2:0]  ARSIZE_M, AWSIZE_M;
    logic [1:0]  ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
    logic        ARVALID_M, ARREADY_M, RVALID_M, RREADY_M, RLAST_M;
    logic        AWVALID_M, AWREADY_M, WVALID_M, WREADY_M, WLAST_M;
    logic        BVALID_M, BREADY_M;

    axi_master_bridge #(.ID(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .stall(stall), .err(err),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
        .BREADY_M(BREADY_M)
    );

    // ---------------- slave model ----------------
    int          cfg_ar_delay, cfg_aw_delay, cfg_w_delay, cfg_r_delay, cfg_b_delay;
    logic [1:0]  cfg_rresp, cfg_bresp;
    bit          cfg_id_bad, cfg_rlast_bad;
    logic [31:0] mem [logic [31:0]];

    function automatic bit unmapped(input logic [31:0] a);
        return a[31:16] == 16'hFFFF;
    endfunction

    initial begin
        int ar_wait, aw_wait, w_wait, r_cnt, b_cnt;
        bit hs_ar, hs_aw, hs_w, hs_r, hs_b, r_pend, aw_got, w_got, b_pend;
        logic [31:0] s_araddr, s_awaddr, s_wdata, rd_addr, wr_addr, wr_data, m;
        logic [3:0]  s_wstrb, wr_strb;
        ARREADY_M = 0; AWREADY_M = 0; WREADY_M = 0; RVALID_M = 0; BVALID_M = 0;
        RID_M = '0; BID_M = '0; RDATA_M = 0; RRESP_M = 0; RLAST_M = 0; BRESP_M = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_cnt = 0; b_cnt = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        forever begin
            @(negedge clk);
            hs_ar = ARVALID_M & ARREADY_M;  hs_aw = AWVALID_M & AWREADY_M;
            hs_w  = WVALID_M & WREADY_M;    hs_r  = RVALID_M & RREADY_M;
            hs_b  = BVALID_M & BREADY_M;
            s_araddr = ARADDR_M; s_awaddr = AWADDR_M; s_wdata = WDATA_M; s_wstrb = WSTRB_M;
            @(posedge clk); #1;
            if (rst) begin
                ARREADY_M = 0; AWREADY_M = 0; WREADY_M = 0; RVALID_M = 0; BVALID_M = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; r_cnt = 0; b_cnt = 0;
                r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
            end else begin
                if (hs_ar) begin
                    ARREADY_M = 0; ar_wait = 0; rd_addr = s_araddr; r_pend = 1; r_cnt = 0;
                end else if (ARVALID_M && !ARREADY_M) begin
                    if (ar_wait >= cfg_ar_delay) ARREADY_M = 1; else ar_wait++;
                end
                if (hs_r) RVALID_M = 0;
                else if (r_pend && !RVALID_M) begin
                    if (r_cnt >= cfg_r_delay) begin
                        RVALID_M = 1; r_pend = 0;
                        RID_M    = cfg_id_bad ? `AXI_ID_BITS'(5) : '0;
                        RLAST_M  = !cfg_rlast_bad;
                        RRESP_M  = unmapped(rd_addr) ? 2'b11 : cfg_rresp;
                        RDATA_M  = (unmapped(rd_addr) || !mem.exists(rd_addr)) ? 32'h0 : mem[rd_addr];
                    end else r_cnt++;
                end
                if (hs_aw) begin
                    AWREADY_M = 0; aw_wait = 0; wr_addr = s_awaddr; aw_got = 1;
                end else if (AWVALID_M && !AWREADY_M) begin
                    if (aw_wait >= cfg_aw_delay) AWREADY_M = 1; else aw_wait++;
                end
                if (hs_w) begin
                    WREADY_M = 0; w_wait = 0; wr_data = s_wdata; wr_strb = s_wstrb; w_got = 1;
                end else if (WVALID_M && !WREADY_M) begin
                    if (w_wait >= cfg_w_delay) WREADY_M = 1; else w_wait++;
                end
                if (aw_got && w_got) begin
                    if (!unmapped(wr_addr)) begin
                        m = mem.exists(wr_addr) ? mem[wr_addr] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (wr_strb[i]) m[8*i +: 8] = wr_data[8*i +: 8];
                        mem[wr_addr] = m;
                    end
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                if (hs_b) BVALID_M = 0;
                else if (b_pend && !BVALID_M) begin
                    if (b_cnt >= cfg_b_delay) begin
                        BVALID_M = 1; b_pend = 0;
                        BID_M    = cfg_id_bad ? `AXI_ID_BITS'(5) : '0;
                        BRESP_M  = unmapped(wr_addr) ? 2'b11 : cfg_bresp;
                    end else b_cnt++;
                end
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          is_read;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_e,
                          input bit pulse, output int lat, output int ar_cyc, output int w_only);
        exp_t e;
        e.rdata = exp_rd; e.err = exp_e; e.is_read = !w;
        sb.push_back(e);
        lat = 0; ar_cyc = 0; w_only = 0;
        @(posedge clk); #1;
        req = 1; we = w; addr = a; wdata = d; wstrb = s;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            lat++;
            if (ARVALID_M) begin
                ar_cyc++;
                check("araddr", ARADDR_M, a);
                check("ar_attr", {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M}, {4'h0, 4'h0, 3'b010, 2'b01});
                check("ar_while_b_pending", BREADY_M, 0);
            end
            if (AWVALID_M) begin
                check("awaddr", AWADDR_M, a);
                check("aw_attr", {AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M}, {4'h0, 4'h0, 3'b010, 2'b01});
            end
            if (WVALID_M) begin
                check("w_beat", {WLAST_M, WSTRB_M, WDATA_M}, {1'b1, s, d});
                if (!AWVALID_M) w_only++;
            end
            if (!stall) break;
        end
        check("done_reached", stall, 0);
        e = sb.pop_front();
        check("err_at_done", err, e.err);
        if (e.is_read) check("rdata", rdata, e.rdata);
        @(posedge clk); #1;
        req = 0;
        @(negedge clk);
        if (pulse) check("err_pulse_end", err, 0);
        check("idle_after", {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, stall}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ac, wo;
        rst = 1; req = 0; we = 0; addr = 0; wdata = 0; wstrb = 0;
        cfg_ar_delay = 0; cfg_aw_delay = 0; cfg_w_delay = 0; cfg_r_delay = 0; cfg_b_delay = 0;
        cfg_rresp = 2'b00; cfg_bresp = 2'b00; cfg_id_bad = 0; cfg_rlast_bad = 0;
        mem[32'h0000_1000] = 32'hDEAD_BEEF;
        mem[32'h0000_2000] = 32'hAAAA_AAAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valids", {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err_stall", {err, stall}, 0);
        @(posedge clk); #1; rst = 0;

        // zero-wait read: DONE is the 4th cycle counting the req cycle
        do_req(0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 0, 1, lat, ac, wo);
        check("rd_latency", lat, 4);
        check("rd_ar_cycles", ac, 1);

        // AW accepted 3 cycles before W
        cfg_w_delay = 3;
        do_req(1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 0, 0, 1, lat, ac, wo);
        check("w_only_cycles", wo, 3);
`ifdef AXI_MASTER_POSTED_WRITE_EN
        check("wr_slow_latency", lat, 6);
`else
        check("wr_slow_latency", lat, 7);
`endif
        cfg_w_delay = 0;
        do_req(0, 32'h0000_2000, 0, 0, 32'hAAAA_5678, 0, 1, lat, ac, wo);

        do_req(1, 32'h0000_1004, 32'hCAFE_F00D, 4'hF, 0, 0, 1, lat, ac, wo);
`ifdef AXI_MASTER_POSTED_WRITE_EN
        check("wr_latency", lat, 3);
`else
        check("wr_latency", lat, 4);
`endif
        do_req(0, 32'h0000_1004, 0, 0, 32'hCAFE_F00D, 0, 1, lat, ac, wo);

        // default slave DECERR
        do_req(0, 32'hFFFF_0000, 0, 0, 32'h0, 1, 1, lat, ac, wo);

        // ARREADY withheld for 10 cycles
        cfg_ar_delay = 10;
        do_req(0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 0, 1, lat, ac, wo);
        check("ar_hold_cycles", ac, 11);
        check("ar_hold_latency", lat, 14);
        cfg_ar_delay = 0;

        cfg_rresp = 2'b10;
        do_req(0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 1, 1, lat, ac, wo);
        cfg_rresp = 2'b00;
        cfg_id_bad = 1;
        do_req(0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 1, 1, lat, ac, wo);
        cfg_id_bad = 0;
        cfg_rlast_bad = 1;
        do_req(0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 1, 1, lat, ac, wo);
        cfg_rlast_bad = 0;

`ifndef AXI_MASTER_POSTED_WRITE_EN
        cfg_bresp = 2'b10;
        do_req(1, 32'h0000_1008, 32'h5555_5555, 4'hF, 0, 1, 1, lat, ac, wo);
        cfg_bresp = 2'b00;

        // reset while waiting for B
        cfg_b_delay = 20;
        @(posedge clk); #1;
        req = 1; we = 1; addr = 32'h0000_100C; wdata = 32'h7777_7777; wstrb = 4'hF;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (BREADY_M) break;
        end
        check("b_state_reached", BREADY_M, 1);
        @(posedge clk); #1;
        rst = 1; req = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_b", {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, stall, err}, 0);
        @(posedge clk); #1;
        rst = 0; cfg_b_delay = 0;
        do_req(0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 0, 1, lat, ac, wo);
        check("post_rst_latency", lat, 4);
`else
        // posted write, slow SLVERR B, read queued behind it
        cfg_b_delay = 5; cfg_bresp = 2'b10;
        do_req(1, 32'h0000_3000, 32'h0BAD_F00D, 4'hF, 0, 0, 1, lat, ac, wo);
        check("posted_latency", lat, 3);
        check("b_pending_before_b", {BREADY_M, BVALID_M, err}, 3'b100);
        do_req(0, 32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 1, 0, lat, ac, wo);
        check("read_after_b_ar_cycles", ac, 1);
        check("sticky_err", err, 1);
        cfg_b_delay = 0; cfg_bresp = 2'b00;
        do_req(0, 32'h0000_3000, 0, 0, 32'h0BAD_F00D, 1, 0, lat, ac, wo);
        check("sticky_err_holds", err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
